// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared encodings for the data-memory access unit: access
//                size codes, FSM state codes, default memory size and the
//                legality check applied to every incoming request.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam int MEM_BYTES_DEFAULT = 64;

    // Access size encodings as presented on the request interface
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // FSM state encodings
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_RSET  = 4'd1;
    localparam logic [3:0] ST_RSTB  = 4'd2;
    localparam logic [3:0] ST_RCAP  = 4'd3;
    localparam logic [3:0] ST_WSET  = 4'd4;
    localparam logic [3:0] ST_WSTB  = 4'd5;
    localparam logic [3:0] ST_WHOLD = 4'd6;
    localparam logic [3:0] ST_DONE  = 4'd7;
    localparam logic [3:0] ST_ERR   = 4'd8;

    // A request is illegal when the size is reserved, the address is not
    // naturally aligned for the size, or a full word at addr would run past
    // the end of memory (the range check applies to every size).
    function automatic logic access_illegal(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [31:0] max_addr
    );
        logic w_bad;
        w_bad = 1'b0;
        if (size == SZ_RSVD)                       w_bad = 1'b1;
        if (size == SZ_HALF && addr[0] != 1'b0)    w_bad = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00) w_bad = 1'b1;
        if (addr > max_addr)                       w_bad = 1'b1;
        return w_bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Request/response bundle between the control unit and the
//                access unit, plus the data-memory strobe/address/data bus.
//                master = control unit + memory side, slave = access unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if;

    // Request side
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;

    // Response side
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    // Data memory bus
    logic        mRD;
    logic        mWR;
    logic [31:0] address;
    logic [31:0] DataIn;
    logic [31:0] DMOut;

    modport master (
        output req, we, size, sext, addr, wdata, DMOut,
        input  busy, done, err, rdata, mRD, mWR, address, DataIn
    );

    modport slave (
        input  req, we, size, sext, addr, wdata, DMOut,
        output busy, done, err, rdata, mRD, mWR, address, DataIn
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_ext
//  Description : Picks the addressed byte/half/word out of a big-endian
//                memory read word (addressed byte sits in [31:24]) and
//                zero- or sign-extends it to 32 bits.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] i_dmout,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic [31:0] o_result
);

    logic w_fill;

    // Extract the leading bytes and fill the upper bits per sign mode
    always_comb begin
        w_fill   = i_sext & i_dmout[31];
        o_result = i_dmout;
        case (i_size)
            SZ_BYTE: o_result = {{24{w_fill}}, i_dmout[31:24]};
            SZ_HALF: o_result = {{16{w_fill}}, i_dmout[31:16]};
            default: o_result = i_dmout;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : CPU-side initiator for the byte-addressed big-endian data
//                memory. Takes one load/store request at a time, sequences
//                mRD/mWR, performs sub-word loads with extension and
//                read-modify-write for byte/half stores, and returns a
//                registered result with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
)(
    input  logic              CLK,
    input  logic              Reset,
    mem_access_unit_if.slave  bus
);

    // Highest start address at which a full word still fits in memory
    localparam logic [31:0] c_max_addr = 32'(MEM_BYTES - 4);

    logic [3:0]  r_state;
    logic [3:0]  w_next;

    // Request fields captured on acceptance
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [31:0] r_wdata;

    // Registered outputs
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_mrd;
    logic        r_mwr;
    logic [31:0] r_rdata;
    logic [31:0] r_address;
    logic [31:0] r_datain;

    logic [31:0] w_load_val;
    logic [31:0] w_merged;
    logic [31:0] w_wr_word;
    logic        w_accept;

    assign w_accept = (r_state == ST_IDLE) && bus.req;

    mem_load_ext u_load_ext (
        .i_dmout  (bus.DMOut),
        .i_size   (r_size),
        .i_sext   (r_sext),
        .o_result (w_load_val)
    );

    // Overlay the right-justified store data onto the word read back in RCAP
    always_comb begin
        w_merged = r_wdata;
        case (r_size)
            SZ_BYTE: w_merged = {r_wdata[7:0],  bus.DMOut[23:0]};
            SZ_HALF: w_merged = {r_wdata[15:0], bus.DMOut[15:0]};
            default: w_merged = r_wdata;
        endcase
        // A word store goes straight from IDLE to WSET using the live input
        w_wr_word = (r_state == ST_IDLE) ? bus.wdata : w_merged;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    if (access_illegal(bus.size, bus.addr, c_max_addr))
                        w_next = ST_ERR;
                    else if (bus.we && bus.size == SZ_WORD)
                        w_next = ST_WSET;
                    else
                        w_next = ST_RSET;
                end
            end
            ST_RSET:  w_next = ST_RSTB;
            ST_RSTB:  w_next = ST_RCAP;
            ST_RCAP:  w_next = r_we ? ST_WSET : ST_DONE;
            ST_WSET:  w_next = ST_WSTB;
            ST_WSTB:  w_next = ST_WHOLD;
            ST_WHOLD: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Capture request fields only when a request is accepted in IDLE
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_we    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_sext  <= 1'b0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sext  <= bus.sext;
            r_wdata <= bus.wdata;
        end
    end

    // Outputs are flops decoded from the next state so strobes never glitch
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_mrd     <= 1'b0;
            r_mwr     <= 1'b0;
            r_rdata   <= 32'd0;
            r_address <= 32'd0;
            r_datain  <= 32'd0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
            r_done <= (w_next == ST_DONE) || (w_next == ST_ERR);
            r_err  <= (w_next == ST_ERR);
            r_mrd  <= (w_next == ST_RSTB) || (w_next == ST_RCAP);
            r_mwr  <= (w_next == ST_WSTB);
            if (r_state == ST_IDLE && (w_next == ST_RSET || w_next == ST_WSET))
                r_address <= bus.addr;
            if (w_next == ST_WSET)
                r_datain <= w_wr_word;
            if (r_state == ST_RCAP && !r_we)
                r_rdata <= w_load_val;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.mRD     = r_mrd;
    assign bus.mWR     = r_mwr;
    assign bus.rdata   = r_rdata;
    assign bus.address = r_address;
    assign bus.DataIn  = r_datain;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit with a
//                64-byte zero-initialised big-endian memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_BYTES(64)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Big-endian memory model: byte at address lands in [31:24]
    logic [7:0] mem [0:63] = '{default: 8'h00};
    logic [5:0] w_a;
    assign w_a = bus.address[5:0];
    assign bus.DMOut = (bus.address <= 32'd60) ?
        {mem[w_a], mem[w_a + 6'd1], mem[w_a + 6'd2], mem[w_a + 6'd3]} : 32'd0;

    // Monitors: memory writes, mWR rising edges, strobe cycles, overlap
    int   mwr_rises   = 0;
    int   strobe_cyc  = 0;
    int   overlap_cyc = 0;
    logic prev_mwr    = 1'b0;
    always @(posedge clk) begin
        if (bus.mWR && bus.address <= 32'd60) begin
            mem[w_a]        <= bus.DataIn[31:24];
            mem[w_a + 6'd1] <= bus.DataIn[23:16];
            mem[w_a + 6'd2] <= bus.DataIn[15:8];
            mem[w_a + 6'd3] <= bus.DataIn[7:0];
        end
        if (bus.mWR && !prev_mwr) mwr_rises++;
        if (bus.mRD || bus.mWR)   strobe_cyc++;
        if (bus.mRD && bus.mWR)   overlap_cyc++;
        prev_mwr <= bus.mWR;
    end

    // Issue one request, return cycles from accept edge to done-high
    task automatic do_access(input logic we, input logic [1:0] size, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat);
        @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.size = size; bus.sext = sext;
        bus.addr = addr; bus.wdata = wdata;
        @(posedge clk);
        #1;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.addr = 32'hDEAD_BEEF; bus.wdata = 32'hCAFE_F00D;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.done) lat = 99;
        @(posedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.mRD, bus.mWR} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {bus.busy, bus.done, bus.err, bus.mRD, bus.mWR});
        end
        checks++;
        if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
        checks++;
        if (bus.address !== 32'd0) begin errors++; $display("FAIL reset_address got=%h exp=0", bus.address); end
        checks++;
        if (bus.DataIn !== 32'd0) begin errors++; $display("FAIL reset_datain got=%h exp=0", bus.DataIn); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_store_load;
        int lat;
        do_access(1'b1, 2'b10, 1'b0, 32'd8, 32'h1122_3344, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL wstore_latency got=%0d exp=4", lat); end
        checks++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h1122_3344) begin
            errors++; $display("FAIL wstore_mem got=%h exp=11223344", {mem[8], mem[9], mem[10], mem[11]});
        end
        do_access(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL wload_latency got=%0d exp=4", lat); end
        checks++;
        if (bus.rdata !== 32'h1122_3344) begin errors++; $display("FAIL wload_rdata got=%h exp=11223344", bus.rdata); end
    endtask

    task automatic test_byte_store_rmw;
        int lat;
        int rises0;
        rises0 = mwr_rises;
        // Upper wdata bits are junk: only wdata[7:0] may reach memory
        do_access(1'b1, 2'b00, 1'b0, 32'd9, 32'hFFFF_FFAB, lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL bstore_latency got=%0d exp=7", lat); end
        checks++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h11AB_3344) begin
            errors++; $display("FAIL bstore_mem got=%h exp=11ab3344", {mem[8], mem[9], mem[10], mem[11]});
        end
        checks++;
        if (mwr_rises - rises0 !== 1) begin errors++; $display("FAIL bstore_mwr_pulses got=%0d exp=1", mwr_rises - rises0); end
    endtask

    task automatic test_subword_loads;
        int lat;
        do_access(1'b1, 2'b01, 1'b0, 32'd10, 32'h1234_8001, lat);
        checks++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h11AB_8001) begin
            errors++; $display("FAIL hstore_mem got=%h exp=11ab8001", {mem[8], mem[9], mem[10], mem[11]});
        end
        do_access(1'b0, 2'b01, 1'b1, 32'd10, 32'h0, lat);
        checks++;
        if (bus.rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL hload_sext got=%h exp=ffff8001", bus.rdata); end
        do_access(1'b0, 2'b01, 1'b0, 32'd10, 32'h0, lat);
        checks++;
        if (bus.rdata !== 32'h0000_8001) begin errors++; $display("FAIL hload_zext got=%h exp=00008001", bus.rdata); end
        do_access(1'b0, 2'b00, 1'b0, 32'd8, 32'h0, lat);
        checks++;
        if (bus.rdata !== 32'h0000_0011) begin errors++; $display("FAIL bload_zext got=%h exp=00000011", bus.rdata); end
        do_access(1'b0, 2'b00, 1'b1, 32'd9, 32'h0, lat);
        checks++;
        if (bus.rdata !== 32'hFFFF_FFAB) begin errors++; $display("FAIL bload_sext got=%h exp=ffffffab", bus.rdata); end
    endtask

    task automatic test_errors;
        int lat;
        int strobe0;
        strobe0 = strobe_cyc;
        do_access(1'b0, 2'b10, 1'b0, 32'd6, 32'h0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL err_misalign_latency got=%0d exp=1", lat); end
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL err_misalign_flag got=%b exp=1", bus.err); end
        checks++;
        if (bus.rdata !== 32'hFFFF_FFAB) begin errors++; $display("FAIL err_rdata_kept got=%h exp=ffffffab", bus.rdata); end
        do_access(1'b0, 2'b01, 1'b0, 32'd11, 32'h0, lat);
        checks++;
        if (bus.err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_half_odd got=%b/%0d exp=1/1", bus.err, lat); end
        do_access(1'b0, 2'b10, 1'b0, 32'd61, 32'h0, lat);
        checks++;
        if (bus.err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_range_word got=%b/%0d exp=1/1", bus.err, lat); end
        do_access(1'b1, 2'b00, 1'b0, 32'd61, 32'h55, lat);
        checks++;
        if (bus.err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_range_byte got=%b/%0d exp=1/1", bus.err, lat); end
        do_access(1'b0, 2'b11, 1'b0, 32'd8, 32'h0, lat);
        checks++;
        if (bus.err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_size_rsvd got=%b/%0d exp=1/1", bus.err, lat); end
        checks++;
        if (strobe_cyc - strobe0 !== 0) begin errors++; $display("FAIL err_strobes got=%0d exp=0", strobe_cyc - strobe0); end
        // Legal access at the last fitting address must not flag an error
        do_access(1'b0, 2'b10, 1'b0, 32'd60, 32'h0, lat);
        checks++;
        if (bus.err !== 1'b0 || lat !== 4 || bus.rdata !== 32'd0) begin
            errors++; $display("FAIL edge_addr60 got=%b/%0d/%h exp=0/4/00000000", bus.err, lat, bus.rdata);
        end
    endtask

    task automatic test_reset_mid_rmw;
        int rises0;
        rises0 = mwr_rises;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sext = 1'b0;
        bus.addr = 32'd8; bus.wdata = 32'h0000_00EE;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        // Cycles after accept: RSET, RSTB, RCAP, then WSET
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.mRD, bus.mWR} !== 5'b0) begin
            errors++; $display("FAIL midreset_flags got=%b exp=00000", {bus.busy, bus.done, bus.err, bus.mRD, bus.mWR});
        end
        checks++;
        if (bus.rdata !== 32'd0 || bus.address !== 32'd0 || bus.DataIn !== 32'd0) begin
            errors++; $display("FAIL midreset_regs got=%h/%h/%h exp=0/0/0", bus.rdata, bus.address, bus.DataIn);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (mwr_rises - rises0 !== 0) begin errors++; $display("FAIL midreset_mwr got=%0d exp=0", mwr_rises - rises0); end
        checks++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h11AB_8001) begin
            errors++; $display("FAIL midreset_mem got=%h exp=11ab8001", {mem[8], mem[9], mem[10], mem[11]});
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.sext = 1'b0;
        bus.addr = 32'd8; bus.wdata = 32'h0;
        @(posedge clk);
        // Each load: 4 busy cycles (done in the 4th), then one IDLE cycle
        for (int i = 1; i <= 15; i++) begin
            #1;
            checks++;
            if (bus.busy !== ((i % 5) != 0)) begin
                errors++; $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", i, bus.busy, ((i % 5) != 0));
            end
            checks++;
            if (bus.done !== ((i % 5) == 4)) begin
                errors++; $display("FAIL b2b_done cycle=%0d got=%b exp=%b", i, bus.done, ((i % 5) == 4));
            end
            @(posedge clk);
        end
        #1;
        bus.req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rdata !== 32'h11AB_8001) begin
            errors++; $display("FAIL b2b_final got=%b/%h exp=0/11ab8001", bus.busy, bus.rdata);
        end
        checks++;
        if (overlap_cyc !== 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp=0", overlap_cyc); end
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sext = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'd0;
        test_reset();
        test_word_store_load();
        test_byte_store_rmw();
        test_subword_loads();
        test_errors();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
